// File: rtl/operand_fetch.sv
// Operand-fetch sequencer: turns one two-source read request into two back-to-back
// register-file reads and returns the pair. Optional macro OPERAND_FETCH_ZERO_REG_EN hardwires r0 to zero.
module operand_fetch #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs_a,
    input  logic [ADDR_W-1:0] req_rs_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] rf_address,
    input  logic [DATA_W-1:0] rf_register,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_B = 3'd1,
        CAPT_A  = 3'd2,
        CAPT_B  = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rf_address_q, rf_address_d;
    logic [ADDR_W-1:0] rs_b_q, rs_b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] cap_a, cap_b;

`ifdef OPERAND_FETCH_ZERO_REG_EN
    // rf_address already holds rs_b by CAPT_A, so rs_a must be kept for the zero test.
    logic [ADDR_W-1:0] rs_a_q, rs_a_d;

    assign cap_a = (rs_a_q == '0) ? '0 : rf_register;
    assign cap_b = (rs_b_q == '0) ? '0 : rf_register;

    always_comb begin
        rs_a_d = rs_a_q;
        if (state_q == IDLE && req_valid) begin
            rs_a_d = req_rs_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_a_q <= '0;
        end else begin
            rs_a_q <= rs_a_d;
        end
    end
`else
    assign cap_a = rf_register;
    assign cap_b = rf_register;
`endif

    always_comb begin
        state_d      = state_q;
        rf_address_d = rf_address_q;
        rs_b_d       = rs_b_q;
        tag_d        = tag_q;
        out_tag_d    = out_tag_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rs_b_d       = req_rs_b;
                    tag_d        = req_tag;
                    rf_address_d = req_rs_a;
                    state_d      = ISSUE_B;
                end
            end
            ISSUE_B: begin
                rf_address_d = rs_b_q;
                state_d      = CAPT_A;
            end
            CAPT_A: begin
                op_a_d  = cap_a;
                state_d = CAPT_B;
            end
            CAPT_B: begin
                op_b_d      = cap_b;
                out_tag_d   = tag_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rf_address_q <= '0;
            rs_b_q       <= '0;
            tag_q        <= '0;
            out_tag_q    <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_address_q <= rf_address_d;
            rs_b_q       <= rs_b_d;
            tag_q        <= tag_d;
            out_tag_q    <= out_tag_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rf_address = rf_address_q;
    assign out_valid  = out_valid_q;
    assign out_op_a   = op_a_q;
    assign out_op_b   = op_b_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a synchronous-read 8x32 register-file model.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_rs_a;
    logic [2:0]  req_rs_b;
    logic [3:0]  req_tag;
    logic [2:0]  rf_address;
    logic [31:0] rf_register;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [3:0]  out_tag;

    logic [31:0] regs [8];
    int          n_vec;
    int          n_miss;

    operand_fetch #(.ADDR_W(3), .DATA_W(32), .TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs_a    (req_rs_a),
        .req_rs_b    (req_rs_b),
        .req_tag     (req_tag),
        .rf_address  (rf_address),
        .rf_register (rf_register),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op_a    (out_op_a),
        .out_op_b    (out_op_b),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: address held in cycle N appears on rf_register in cycle N+1.
    always @(posedge clk) rf_register <= regs[rf_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request with out_ready held high and checks the whole 3-cycle sequence.
    task automatic do_req(input logic [2:0] a, input logic [2:0] b, input logic [3:0] t,
                          input logic [31:0] ea, input logic [31:0] eb);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rs_a  = a;
        req_rs_b  = b;
        req_tag   = t;
        tick();
        req_valid = 1'b0;
        req_rs_a  = ~a;
        req_rs_b  = ~b;
        req_tag   = ~t;
        chk("rf_addr_a", 32'(rf_address), 32'(a));
        chk("busy", 32'(req_ready), 32'd0);
        tick();
        chk("rf_addr_b", 32'(rf_address), 32'(b));
        tick();
        chk("early_valid", 32'(out_valid), 32'd0);
        tick();
        chk("valid", 32'(out_valid), 32'd1);
        chk("op_a", out_op_a, ea);
        chk("op_b", out_op_b, eb);
        chk("tag", 32'(out_tag), 32'(t));
        tick();
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_zero_a;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 8; i++) regs[i] = 32'h0;
        regs[0] = 32'h5555_5555;
        regs[1] = 32'h0000_0011;
        regs[2] = 32'hCAFE_0002;
        regs[3] = 32'hDEAD_BEEF;
        regs[5] = 32'h1234_5678;
        regs[7] = 32'h0000_FFFF;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs_a  = 3'd6;
        req_rs_b  = 3'd6;
        req_tag   = 4'h9;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_a", out_op_a, 32'd0);
        chk("rst_op_b", out_op_b, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_rf_addr", 32'(rf_address), 32'd0);

        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        do_req(3'd3, 3'd5, 4'hA, 32'hDEAD_BEEF, 32'h1234_5678);

        // Backpressure: execute stalls for 5 cycles while decode keeps requesting.
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_rs_a  = 3'd5;
        req_rs_b  = 3'd3;
        req_tag   = 4'h6;
        tick();
        req_rs_a = 3'd1;
        req_rs_b = 3'd2;
        req_tag  = 4'hE;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_op_a", out_op_a, 32'h1234_5678);
            chk("bp_op_b", out_op_b, 32'hDEAD_BEEF);
            chk("bp_tag", 32'(out_tag), 32'h6);
            tick();
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_ready_back", 32'(req_ready), 32'd1);
        chk("bp_hold_op_a", out_op_a, 32'h1234_5678);
        tick();
        chk("bp_still_idle", 32'(req_ready), 32'd1);
        chk("bp_no_revalid", 32'(out_valid), 32'd0);

        do_req(3'd7, 3'd7, 4'h3, 32'h0000_FFFF, 32'h0000_FFFF);

        // Reset lands while the FSM is in CAPT_A; the request must vanish.
        req_valid = 1'b1;
        req_rs_a  = 3'd2;
        req_rs_b  = 3'd1;
        req_tag   = 4'h5;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_op_a", out_op_a, 32'd0);
        chk("mid_rst_tag", 32'(out_tag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        do_req(3'd2, 3'd1, 4'hC, 32'hCAFE_0002, 32'h0000_0011);

`ifdef OPERAND_FETCH_ZERO_REG_EN
        exp_zero_a = 32'h0;
`else
        exp_zero_a = 32'h5555_5555;
`endif
        do_req(3'd0, 3'd1, 4'hF, exp_zero_a, 32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
